pulse_expander: RTL and testbench
=================================

PULSE_EXPANDER -- requirements
Module: pulse_expander

Interface
REQ-001 Parameter RATIO, default 3, sets the number of output pulses per accepted input pulse (legal range 1..255).
REQ-002 Parameter GAP, default 1, sets the idle cycles after every output pulse (legal range 0..255).
REQ-003 Parameter PEND_W, default 2, sets the pending-counter width; capacity is PMAX = 2^PEND_W-1.
REQ-004 clk  input  1  rising-edge clock; the block SHALL be fully synchronous to clk.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in  input  1  request; each cycle sampled high SHALL count as one request.
REQ-007 out  output  1  single-cycle output pulses, Moore-decoded from state.
REQ-008 busy  output  1  high whenever the FSM is not in IDLE.
REQ-009 ovf  output  1  sticky overflow flag, meaningful only when PULSE_EXPANDER_OVF_EN is defined.
REQ-010 clr_ovf  input  1  synchronous clear of ovf.

Function
REQ-011 The FSM SHALL have three states:
- IDLE: out=0.
- PULSE: out=1, exactly one cycle.
- GAP: out=0, lasts GAP cycles.
REQ-012 IDLE transitions SHALL be:
- to PULSE when in=1 or pend>0, loading remaining=RATIO;
- a pend>0 start consumes one pending request, and pend takes priority over a simultaneous in, which is then queued;
- stay in IDLE otherwise.
REQ-013 PULSE transitions SHALL first decrement remaining, then:
- GAP>0: to GAP with the gap counter loaded to GAP;
- GAP=0: apply the REQ-014 end-of-gap decision immediately.
REQ-014 At the end of GAP the FSM SHALL choose, in this priority order:
- remaining>0: to PULSE;
- else pend>0: to PULSE, pend-1, remaining=RATIO;
- else in=1: to PULSE, remaining=RATIO;
- else: to IDLE.
REQ-015 Latency: in sampled high in IDLE with pend=0 SHALL produce out=1 on the next cycle.
REQ-016 An in that is not consumed in the same cycle SHALL increment pend.
REQ-017 When in and a pend consume coincide, pend SHALL stay unchanged and the in is queued.
REQ-018 When pend=PMAX and an in cannot be consumed or queued, the request SHALL be dropped and ovf set on the next edge.
REQ-019 pend SHALL never wrap; remaining and the gap counter SHALL be 8 bits wide.

Reset
REQ-020 While rst_n=0, regardless of clk, the block SHALL hold: state=IDLE, out=0, busy=0, pend=0, remaining=0, ovf=0.
REQ-021 Reset mid-burst SHALL abort the burst and discard all pending requests; no pulses SHALL follow the release of reset.

Configuration
REQ-022 With PULSE_EXPANDER_OVF_EN defined:
- ovf SHALL be sticky;
- clr_ovf=1 SHALL clear ovf on the next edge;
- a new overflow in the same cycle as clr_ovf wins, and ovf stays 1.
REQ-023 With PULSE_EXPANDER_OVF_EN undefined:
- ovf SHALL be tied to 0;
- clr_ovf SHALL be ignored;
- drop behaviour is unchanged.

Structure
REQ-024 Package pulse_expander_pkg SHALL hold the state encoding (IDLE=0, PULSE=1, GAP=2, 2-bit), the parameter defaults and the counter width constant (8).
REQ-025 The saturating up/down pending counter SHALL be the single sub-module pend_counter, with inputs inc and dec and outputs full and empty.

Verification (RATIO=3, GAP=1, PEND_W=2 unless stated; cycle 0 = first in)
REQ-026 Single in at cycle 0 -> out=1 at cycles 1,3,5 only; busy=1 at cycles 1-6; IDLE at cycle 7.
REQ-027 in at cycles 0 and 2 -> out=1 at cycles 1,3,5,7,9,11; pend returns to 0.
REQ-028 in held high for cycles 0-4 with the macro defined -> cycle 0 starts the burst, cycles 1-3 fill pend to 3, cycle 4 is dropped; ovf=1 from cycle 5; exactly 12 output pulses.
REQ-029 Scenario REQ-028 with clr_ovf at cycle 8 -> ovf=0 from cycle 9; with the macro undefined -> ovf=0 throughout.
REQ-030 rst_n low during cycle 3 of REQ-026 -> out=0 and busy=0 immediately; no out pulses after release.
REQ-031 GAP=0, single in at cycle 0 -> out=1 at cycles 1,2,3 contiguously; IDLE at cycle 4.

Source files
------------

// File: rtl/pulse_expander_pkg.sv
// rtl/pulse_expander_pkg.sv - shared state encoding, parameter defaults and counter width
package pulse_expander_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam int DEF_RATIO  = 3;
  localparam int DEF_GAP    = 1;
  localparam int DEF_PEND_W = 2;
  localparam int CNT_W      = 8;

endpackage

// File: rtl/pulse_expander_if.sv
// rtl/pulse_expander_if.sv - request/pulse bundle between requester and expander
interface pulse_expander_if;
  logic in;
  logic clr_ovf;
  logic out;
  logic busy;
  logic ovf;

  modport master (output in, clr_ovf, input out, busy, ovf);
  modport slave  (input in, clr_ovf, output out, busy, ovf);
endinterface

// File: rtl/pulse_expander_pend_counter.sv
// rtl/pulse_expander_pend_counter.sv - saturating up/down count of queued requests
module pend_counter #(
  parameter int W = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic empty
);

  logic [W-1:0] count;

  assign full  = &count;
  assign empty = (count == '0);

  // Simultaneous inc and dec cancel; the count never wraps in either direction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && !dec && !full) begin
      count <= count + 1'b1;
    end else if (dec && !inc && !empty) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/pulse_expander.sv
// rtl/pulse_expander.sv - expands each request into RATIO spaced pulses; PULSE_EXPANDER_OVF_EN enables sticky ovf
module pulse_expander
  import pulse_expander_pkg::*;
#(
  parameter int RATIO  = DEF_RATIO,
  parameter int GAP    = DEF_GAP,
  parameter int PEND_W = DEF_PEND_W
) (
  input  logic             clk,
  input  logic             rst_n,
  pulse_expander_if.slave  bus
);

  state_t           state;
  logic [CNT_W-1:0] remaining;
  logic [CNT_W-1:0] gap_cnt;
  logic [CNT_W-1:0] rem_eff;
  logic             out_q;
  logic             busy_q;
  logic             ovf_q;
  logic             pend_full;
  logic             pend_empty;
  logic             at_end;
  logic             keep_going;
  logic             may_start;
  logic             pend_dec;
  logic             pend_inc;
  logic             take_in;
  logic             start_new;
  logic             drop;

  // Decision point: end of gap (or the pulse itself when GAP is 0); pending work beats a fresh request.
  always_comb begin
    rem_eff    = (state == S_PULSE) ? remaining - 1'b1 : remaining;
    at_end     = ((state == S_PULSE) && (GAP == 0)) ||
                 ((state == S_GAP) && (gap_cnt == CNT_W'(1)));
    keep_going = at_end && (rem_eff != '0);
    may_start  = (state == S_IDLE) || (at_end && (rem_eff == '0));
    pend_dec   = may_start && !pend_empty;
    take_in    = may_start && pend_empty && bus.in;
    start_new  = pend_dec || take_in;
    pend_inc   = bus.in && !take_in;
    drop       = pend_inc && pend_full && !pend_dec;
  end

  pend_counter #(.W(PEND_W)) u_pend (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pend_inc),
    .dec   (pend_dec),
    .full  (pend_full),
    .empty (pend_empty)
  );

  // Burst sequencer with out/busy registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      remaining <= '0;
      gap_cnt   <= '0;
      out_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_new) begin
            state     <= S_PULSE;
            remaining <= CNT_W'(RATIO);
            out_q     <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        S_PULSE: begin
          remaining <= start_new ? CNT_W'(RATIO) : rem_eff;
          if (!at_end) begin
            state   <= S_GAP;
            gap_cnt <= CNT_W'(GAP);
            out_q   <= 1'b0;
          end else if (!(keep_going || start_new)) begin
            state  <= S_IDLE;
            out_q  <= 1'b0;
            busy_q <= 1'b0;
          end
        end
        S_GAP: begin
          if (!at_end) begin
            gap_cnt <= gap_cnt - 1'b1;
          end else if (keep_going || start_new) begin
            state <= S_PULSE;
            out_q <= 1'b1;
            if (start_new) remaining <= CNT_W'(RATIO);
          end else begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= S_IDLE;
          out_q  <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef PULSE_EXPANDER_OVF_EN
  // Sticky overflow; a drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end else if (bus.clr_ovf) begin
      ovf_q <= 1'b0;
    end
  end
`else
  logic unused_ovf;
  assign unused_ovf = drop ^ bus.clr_ovf;
  assign ovf_q      = 1'b0;
`endif

  assign bus.out  = out_q;
  assign bus.busy = busy_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_pulse_expander.sv
// tb/tb_pulse_expander.sv - self-checking bench for pulse_expander
module tb_pulse_expander;

  localparam int R     = 3;
  localparam int G     = 1;
  localparam int PMAX  = 3;
  localparam int NRAND = 2000;
`ifdef PULSE_EXPANDER_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  pulse_expander_if bus_a ();
  pulse_expander_if bus_b ();

  pulse_expander #(.RATIO(3), .GAP(1), .PEND_W(2)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  pulse_expander #(.RATIO(3), .GAP(0), .PEND_W(2)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic in;
    logic out_a;
    logic busy_a;
    logic out_b;
    logic busy_b;
  } vec_t;

  vec_t tbl [9];

  int n_vec = 0;
  int n_err = 0;

  bit   exp_out  [0:NRAND+32];
  bit   exp_busy [0:NRAND+32];
  int   pend_m;
  int   next_free;
  logic ovf_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n         = 1'b0;
    bus_a.in      = 1'b0;
    bus_a.clr_ovf = 1'b0;
    bus_b.in      = 1'b0;
    bus_b.clr_ovf = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Timeline model: a burst started in cycle c owns pulses at c+1+k*(G+1)
  // and keeps the block busy until its next decision cycle c+R*(G+1).
  task automatic model_step(input int c, input logic in_v, input logic clr_v);
    bit dropped;
    dropped = 1'b0;
    if (c >= next_free && (pend_m > 0 || in_v)) begin
      if (pend_m > 0) begin
        pend_m--;
        if (in_v) pend_m++;
      end
      for (int k = 0; k < R; k++) exp_out[c + 1 + k * (G + 1)] = 1'b1;
      for (int j = 1; j <= R * (G + 1); j++) exp_busy[c + j] = 1'b1;
      next_free = c + R * (G + 1);
    end else if (in_v) begin
      if (pend_m < PMAX) pend_m++;
      else dropped = 1'b1;
    end
    if (OVF_EN) begin
      if (dropped) ovf_m = 1'b1;
      else if (clr_v) ovf_m = 1'b0;
    end
  endtask

  initial begin
    logic [15:0] cap_o;
    logic [15:0] cap_b;
    logic        any_out;
    int          cnt;
    logic        in_v;
    logic        clr_v;

    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset state
    rst_n = 1'b0;
    bus_a.in = 1'b0; bus_a.clr_ovf = 1'b0;
    bus_b.in = 1'b0; bus_b.clr_ovf = 1'b0;
    #2;
    check("reset_out", bus_a.out, 1'b0);
    check("reset_busy", bus_a.busy, 1'b0);
    check("reset_ovf", bus_a.ovf, 1'b0);

    // Single request on both gap settings
    do_reset();
    for (int i = 0; i < 9; i++) begin
      bus_a.in = tbl[i].in;
      bus_b.in = tbl[i].in;
      check($sformatf("single_out_a[%0d]", i), bus_a.out, tbl[i].out_a);
      check($sformatf("single_busy_a[%0d]", i), bus_a.busy, tbl[i].busy_a);
      check($sformatf("gap0_out_b[%0d]", i), bus_b.out, tbl[i].out_b);
      check($sformatf("gap0_busy_b[%0d]", i), bus_b.busy, tbl[i].busy_b);
      tick();
    end

    // Requests at cycles 0 and 2: second one is queued
    do_reset();
    for (int c = 0; c < 16; c++) begin
      bus_a.in = (c == 0 || c == 2);
      cap_o[c] = bus_a.out;
      cap_b[c] = bus_a.busy;
      tick();
    end
    bus_a.in = 1'b0;
    check("queued_out_pattern", cap_o, 16'h0AAA);
    check("queued_busy_pattern", cap_b, 16'h1FFE);

    // Held request: fill pend, drop one, clear ovf at cycle 8
    do_reset();
    cnt = 0;
    for (int c = 0; c < 30; c++) begin
      bus_a.in      = (c <= 4);
      bus_a.clr_ovf = (c == 8);
      cnt += int'(bus_a.out);
      if (c == 4)  check("ovf_c4", bus_a.ovf, 1'b0);
      if (c == 5)  check("ovf_c5", bus_a.ovf, OVF_EN);
      if (c == 8)  check("ovf_c8", bus_a.ovf, OVF_EN);
      if (c == 9)  check("ovf_c9", bus_a.ovf, 1'b0);
      if (c == 24) check("hold_busy_c24", bus_a.busy, 1'b1);
      if (c == 25) check("hold_busy_c25", bus_a.busy, 1'b0);
      tick();
    end
    bus_a.clr_ovf = 1'b0;
    check("hold_pulse_count", cnt, 12);

    // Reset in the middle of a burst
    do_reset();
    bus_a.in = 1'b1;
    tick();
    bus_a.in = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_out", bus_a.out, 1'b0);
    check("midrst_busy", bus_a.busy, 1'b0);
    tick();
    rst_n = 1'b1;
    any_out = 1'b0;
    for (int c = 0; c < 12; c++) begin
      any_out |= bus_a.out | bus_a.busy;
      tick();
    end
    check("post_rst_quiet", any_out, 1'b0);

    // Randomized traffic against the timeline model
    do_reset();
    pend_m    = 0;
    next_free = 0;
    ovf_m     = 1'b0;
    for (int i = 0; i <= NRAND + 32; i++) begin
      exp_out[i]  = 1'b0;
      exp_busy[i] = 1'b0;
    end
    for (int c = 0; c < NRAND; c++) begin
      check($sformatf("rand_out[%0d]", c), bus_a.out, exp_out[c]);
      check($sformatf("rand_busy[%0d]", c), bus_a.busy, exp_busy[c]);
      check($sformatf("rand_ovf[%0d]", c), bus_a.ovf, ovf_m);
      in_v  = ($urandom_range(0, 99) < 45);
      clr_v = ($urandom_range(0, 99) < 4);
      bus_a.in      = in_v;
      bus_a.clr_ovf = clr_v;
      model_step(c, in_v, clr_v);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
